// File: rtl/span_capture.sv
// span_capture: encodes a 1-bit raster pixel stream into line-data records.
// Ports: clk/rst_n; pixel,x_pos,y_pos,next_row,next_frame in; rec_* out, frame_err.
module span_capture #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int MAX_RECORDS = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pixel,
  input  logic [9:0]  x_pos,
  input  logic [9:0]  y_pos,
  input  logic        next_row,
  input  logic        next_frame,
  output logic        rec_valid,
  input  logic        rec_ready,
  output logic [7:0]  rec_y,
  output logic [31:0] rec_x,
  output logic [7:0]  rec_count,
  output logic        frame_err
);

  localparam logic [10:0] HA    = 11'(H_ACTIVE);
  localparam logic [10:0] VA    = 11'(V_ACTIVE);
  localparam logic [7:0]  CLS_X = 8'(H_ACTIVE / 4);
  localparam logic [7:0]  MAXR  = 8'(MAX_RECORDS);
  localparam logic [7:0]  MAXM1 = 8'(MAX_RECORDS - 1);

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    CAPTURE = 2'd1,
    FULL    = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;
  state_t      w_frame_st;

  logic        r_prev;
  logic [2:0]  r_ecnt;
  logic [31:0] r_cur;
  logic [31:0] r_last;
  logic        r_err;
  logic        r_wrap;
  logic        r_valid;
  logic [7:0]  r_y;
  logic [31:0] r_x;
  logic [7:0]  r_cnt;
  logic        r_ferr;

  logic        w_run;
  logic        w_cap;
  logic        w_y_ok;
  logic        w_x_ok;
  logic        w_smp;
  logic        w_edge;
  logic        w_ovf;
  logic [31:0] w_fin;
  logic        w_cerr;
  logic        w_close;
  logic        w_emit_row;
  logic        w_term;
  logic        w_emit;
  logic        w_busy;
  logic        w_drop;
  logic        w_err_set;
  logic [7:0]  w_cnt_nx;

  assign w_y_ok = (y_pos[1:0] == 2'b00) && ({1'b0, y_pos} < VA);
  assign w_x_ok = (x_pos[1:0] == 2'b00) && ({1'b0, x_pos} < HA);

  // Frame restart lands in FULL directly when only the terminator fits.
  assign w_frame_st = (MAX_RECORDS == 1) ? FULL : CAPTURE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= SYNC;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      SYNC: begin
        if (next_frame) w_state_nx = w_frame_st;
      end
      CAPTURE: begin
        if (next_frame)
          w_state_nx = w_frame_st;
        else if (w_emit_row && (w_cnt_nx == MAXM1))
          w_state_nx = FULL;
      end
      FULL: begin
        if (next_frame) w_state_nx = w_frame_st;
      end
      default: w_state_nx = SYNC;
    endcase
  end

  always_comb begin
    w_run = 1'b0;
    w_cap = 1'b0;
    unique case (r_state)
      CAPTURE: begin
        w_run = 1'b1;
        w_cap = 1'b1;
      end
      FULL:    w_run = 1'b1;
      default: w_run = 1'b0;
    endcase
  end

  assign w_smp  = w_run && !next_row && !next_frame && w_y_ok && w_x_ok;
  assign w_edge = w_smp && (pixel != r_prev);
  assign w_ovf  = w_edge && r_ecnt[2];

  // Row still high at its end gets a closing toggle at the right border.
  always_comb begin
    w_fin  = r_cur;
    w_cerr = 1'b0;
    if (r_prev) begin
      if (r_ecnt[2]) w_cerr = 1'b1;
      else           w_fin[{r_ecnt[1:0], 3'b000} +: 8] = CLS_X;
    end
  end

  assign w_close    = w_run && next_row && !next_frame && w_y_ok;
  assign w_emit_row = w_close && w_cap && (w_fin != r_last);
  assign w_term     = w_run && next_frame;
  assign w_emit     = w_emit_row || w_term;
  assign w_busy     = r_valid && !rec_ready;
  assign w_drop     = w_emit && w_busy;
  assign w_err_set  = w_ovf || (w_close && w_cerr) || w_drop;
  assign w_cnt_nx   = r_cnt + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b0;
      r_ecnt <= 3'd0;
      r_cur  <= '1;
    end else if (next_row || next_frame) begin
      r_prev <= 1'b0;
      r_ecnt <= 3'd0;
      r_cur  <= '1;
    end else if (w_smp) begin
      r_prev <= pixel;
      if (w_edge && !r_ecnt[2]) begin
        r_cur[{r_ecnt[1:0], 3'b000} +: 8] <= x_pos[9:2];
        r_ecnt <= r_ecnt + 3'd1;
      end
    end
  end

  // last_x tracks every row-record decision, dropped ones included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_last <= '1;
    else if (next_frame) r_last <= '1;
    else if (w_emit_row) r_last <= w_fin;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_y     <= 8'd0;
      r_x     <= 32'd0;
    end else if (w_emit && !w_busy) begin
      r_valid <= 1'b1;
      r_y     <= w_term ? 8'hFF : y_pos[9:2];
      r_x     <= w_term ? 32'hFFFF_FFFF : w_fin;
    end else if (rec_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Frame wrap runs one cycle after next_frame so the terminator is
  // counted and a terminator drop reaches frame_err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
      r_ferr <= 1'b0;
      r_cnt  <= 8'd0;
    end else begin
      r_wrap <= w_term;
      if (r_wrap) begin
        r_ferr <= r_err;
        r_err  <= w_err_set;
        r_cnt  <= w_emit ? 8'd1 : 8'd0;
      end else begin
        if (w_err_set) r_err <= 1'b1;
        if (w_emit && (r_cnt != MAXR)) r_cnt <= w_cnt_nx;
      end
    end
  end

  assign rec_valid = r_valid;
  assign rec_y     = r_y;
  assign rec_x     = r_x;
  assign rec_count = r_cnt;
  assign frame_err = r_ferr;

endmodule

// File: tb/tb_span_capture.sv
// tb_span_capture: directed checks of span_capture (default and MAX_RECORDS=3).
// Drives sampled columns only; checks records, counts and frame_err.
module tb_span_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pixel;
  logic [9:0]  x_pos;
  logic [9:0]  y_pos;
  logic        next_row;
  logic        next_frame;
  logic        rec_ready;
  logic        rec_valid;
  logic [7:0]  rec_y;
  logic [31:0] rec_x;
  logic [7:0]  rec_count;
  logic        frame_err;
  logic        f_valid;
  logic [7:0]  f_y;
  logic [31:0] f_x;
  logic [7:0]  f_count;
  logic        f_err;

  int checks = 0;
  int failures = 0;
  logic pat [0:159];

  always #5 clk = ~clk;

  span_capture u_dut (
    .clk(clk), .rst_n(rst_n), .pixel(pixel),
    .x_pos(x_pos), .y_pos(y_pos),
    .next_row(next_row), .next_frame(next_frame),
    .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_y(rec_y), .rec_x(rec_x),
    .rec_count(rec_count), .frame_err(frame_err)
  );

  span_capture #(.MAX_RECORDS(3)) u_full (
    .clk(clk), .rst_n(rst_n), .pixel(pixel),
    .x_pos(x_pos), .y_pos(y_pos),
    .next_row(next_row), .next_frame(next_frame),
    .rec_valid(f_valid), .rec_ready(rec_ready),
    .rec_y(f_y), .rec_x(f_x),
    .rec_count(f_count), .frame_err(f_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_pat;
    for (int i = 0; i < 160; i++) pat[i] = 1'b0;
  endtask

  task automatic add_span(input int a, input int b);
    for (int x = a; x < b; x += 4) pat[x / 4] = 1'b1;
  endtask

  task automatic do_row(input int y);
    for (int x = 0; x < 640; x += 4) begin
      x_pos = 10'(x);
      y_pos = 10'(y);
      pixel = pat[x / 4];
      tick();
    end
    pixel    = 1'b0;
    x_pos    = 10'd640;
    next_row = 1'b1;
    tick();
    next_row = 1'b0;
  endtask

  task automatic frame_pulse;
    pixel      = 1'b0;
    x_pos      = 10'd640;
    y_pos      = 10'd480;
    next_frame = 1'b1;
    tick();
    next_frame = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    pixel      = 1'b0;
    x_pos      = 10'd0;
    y_pos      = 10'd0;
    next_row   = 1'b0;
    next_frame = 1'b0;
    rec_ready  = 1'b1;
    clr_pat();
    #12;
    chk("rst_valid", 32'(rec_valid), 32'd0);
    chk("rst_y", 32'(rec_y), 32'd0);
    chk("rst_x", rec_x, 32'd0);
    chk("rst_count", 32'(rec_count), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    #8;
    rst_n = 1'b1;
    tick();

    add_span(292, 428);
    do_row(180);
    chk("sync_ignore", 32'(rec_valid), 32'd0);
    frame_pulse();
    tick();

    do_row(180);
    chk("band_valid", 32'(rec_valid), 32'd1);
    chk("band_y", 32'(rec_y), 32'd45);
    chk("band_x", rec_x, 32'hFFFF_6B49);
    chk("band_cnt", 32'(rec_count), 32'd1);
    do_row(184);
    chk("band_same", 32'(rec_valid), 32'd0);
    clr_pat();
    do_row(220);
    chk("blank_valid", 32'(rec_valid), 32'd1);
    chk("blank_y", 32'(rec_y), 32'd55);
    chk("blank_x", rec_x, 32'hFFFF_FFFF);
    do_row(224);
    chk("blank_same", 32'(rec_valid), 32'd0);
    frame_pulse();
    chk("term_valid", 32'(rec_valid), 32'd1);
    chk("term_y", 32'(rec_y), 32'hFF);
    chk("term_x", rec_x, 32'hFFFF_FFFF);
    chk("term_cnt", 32'(rec_count), 32'd3);
    tick();
    chk("wrap_cnt", 32'(rec_count), 32'd0);
    chk("wrap_ferr", 32'(frame_err), 32'd0);

    clr_pat();
    add_span(340, 380);
    add_span(416, 456);
    do_row(256);
    chk("two_y", 32'(rec_y), 32'd64);
    chk("two_x", rec_x, 32'h7268_5F55);
    do_row(260);
    chk("two_same", 32'(rec_valid), 32'd0);
    chk("two_cnt", 32'(rec_count), 32'd1);
    clr_pat();
    add_span(600, 640);
    do_row(264);
    chk("close_y", 32'(rec_y), 32'd66);
    chk("close_x", rec_x, 32'hFFFF_A096);
    frame_pulse();
    tick();
    chk("close_ferr", 32'(frame_err), 32'd0);

    clr_pat();
    for (int s = 0; s < 6; s++) add_span(8 + 16 * s, 16 + 16 * s);
    do_row(0);
    chk("ovf_y", 32'(rec_y), 32'd0);
    chk("ovf_x", rec_x, 32'h0806_0402);
    frame_pulse();
    tick();
    chk("ovf_ferr", 32'(frame_err), 32'd1);
    frame_pulse();
    tick();
    chk("clean_ferr", 32'(frame_err), 32'd0);

    rec_ready = 1'b0;
    clr_pat();
    add_span(0, 4);
    do_row(4);
    clr_pat();
    add_span(4, 8);
    do_row(8);
    chk("hold_valid", 32'(rec_valid), 32'd1);
    chk("hold_y", 32'(rec_y), 32'd1);
    chk("hold_x", rec_x, 32'hFFFF_0100);
    rec_ready = 1'b1;
    tick();
    chk("ack_drop", 32'(rec_valid), 32'd0);
    do_row(12);
    chk("last_upd", 32'(rec_valid), 32'd0);
    frame_pulse();
    chk("drop_cnt", 32'(rec_count), 32'd3);
    tick();
    chk("drop_ferr", 32'(frame_err), 32'd1);

    rec_ready = 1'b0;
    clr_pat();
    add_span(0, 4);
    do_row(16);
    chk("pre_rst_valid", 32'(rec_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(rec_valid), 32'd0);
    chk("arst_cnt", 32'(rec_count), 32'd0);
    chk("arst_ferr", 32'(frame_err), 32'd0);
    rst_n = 1'b1;
    rec_ready = 1'b1;
    tick();
    do_row(0);
    chk("resync_ignore", 32'(rec_valid), 32'd0);
    frame_pulse();
    tick();

    do_row(0);
    chk("post_sync_valid", 32'(rec_valid), 32'd1);
    chk("full_r1", 32'(f_valid), 32'd1);
    clr_pat();
    add_span(8, 12);
    do_row(4);
    chk("full_r2_x", f_x, 32'hFFFF_0302);
    chk("full_cnt2", 32'(f_count), 32'd2);
    clr_pat();
    add_span(0, 4);
    do_row(8);
    chk("full_quiet1", 32'(f_valid), 32'd0);
    chk("main_r3_y", 32'(rec_y), 32'd2);
    clr_pat();
    add_span(8, 12);
    do_row(12);
    chk("full_quiet2", 32'(f_valid), 32'd0);
    chk("main_cnt4", 32'(rec_count), 32'd4);
    frame_pulse();
    chk("full_term_v", 32'(f_valid), 32'd1);
    chk("full_term_y", 32'(f_y), 32'hFF);
    chk("full_term_cnt", 32'(f_count), 32'd3);
    tick();
    chk("full_wrap_cnt", 32'(f_count), 32'd0);
    chk("full_ferr", 32'(f_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/span_capture.md
Name: span_capture

Overview:
- Inverse of the line renderer: watches a 1-bit pixel stream during raster scan and encodes it into line-data records of the form the renderer consumes.
- Each record is one Y breakpoint (coord/4) plus four X toggle points (coord/4, 255 = unused).
- Sits beside the VGA timing generator; records go to a ROM/RAM writer or host readback FIFO through a valid/ready handshake.

Parameters:
- H_ACTIVE, 640, visible width in pixels; multiple of 4, at most 1020.
- V_ACTIVE, 480, visible height in pixels; multiple of 4.
- MAX_RECORDS, 7, records per frame, terminator included; 1..255.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- pixel  in  1  pixel value at (x_pos, y_pos)
- x_pos  in  10  current pixel column
- y_pos  in  10  current pixel row
- next_row  in  1  one-cycle pulse at end of each row
- next_frame  in  1  one-cycle pulse at end of frame
- rec_valid  out  1  record available
- rec_ready  in  1  consumer accepts the record
- rec_y  out  8  record Y breakpoint (y_pos/4; 255 = terminator)
- rec_x  out  32  four X toggle points, x0 in [7:0] ... x3 in [31:24]
- rec_count  out  8  records emitted this frame
- frame_err  out  1  previous frame lost data (overflow/drop)

Behaviour:
- Reset, asynchronous, clk/rst_n:
  - rec_valid=0, rec_y=0, rec_x=0, rec_count=0, frame_err=0.
  - Internal error flag cleared; state SYNC.
  - Reset mid-record drops the pending record silently.
- States:
  - SYNC: ignore all input until next_frame, then go to CAPTURE.
  - CAPTURE: normal operation.
  - FULL: entered when rec_count reaches MAX_RECORDS-1; no further Y records; leaves on next_frame.
- Sampling:
  - Only in CAPTURE/FULL, only rows with y_pos[1:0]==0 and y_pos<V_ACTIVE, only columns with x_pos[1:0]==0 and x_pos<H_ACTIVE.
  - prev level = 0 at row start.
  - Sample != prev: if edge_cnt<4, cur_x[edge_cnt]=x_pos[9:2] and edge_cnt++; else set error flag.
  - prev takes the sample value on every sample.
- Row close, on a next_row that ends a sampled row:
  - If prev==1, append a close edge H_ACTIVE/4 (error if no slot).
  - Unfilled slots = 255.
  - Compare cur_x to last_x (last emitted set; all 255 at frame start).
  - If different and state CAPTURE: emit record rec_y=y_pos[9:2], rec_x=cur_x; last_x updates.
  - Then clear cur_x/edge_cnt.
- Emit:
  - rec_valid rises the cycle after the next_row pulse.
  - Outputs hold stable until rec_valid && rec_ready; rec_valid drops the next cycle.
  - Same-cycle ready is accepted.
  - A new emit while rec_valid is still high drops the new record and sets the error flag; last_x is still updated.
  - rec_count increments on each emit, counting dropped records too.
- next_frame:
  - In-progress row discarded; next_frame wins over a simultaneous next_row.
  - Terminator record emitted the next cycle: rec_y=255, rec_x=all 255.
  - Error flag set if the terminator is dropped.
  - frame_err loads the error flag; flag clears; rec_count=0; last_x=all 255; state CAPTURE.
- Widths:
  - X/Y stored as bits [9:2], unsigned.
  - rec_count is 8-bit, bounded by MAX_RECORDS, never wraps.

Test Plan:
- Reset, then pixel=1 for 292<=x<428 on rows 180..219, then next_frame → records (y=45, x={73,107,255,255}), (y=55, x=all 255), terminator (255, all 255); rec_count 3→0 on next_frame; frame_err=0.
- Rows 256..295: pixel=1 for x in [340,380) and [416,456) → record y=64, x={85,95,104,114}; identical rows produce no further records.
- pixel=1 from x=600 to row end → close edge 160: x={150,160,255,255}.
- Six spans (12 edges) in one row → first four edges kept; frame_err=1 after next_frame; next clean frame → frame_err=0.
- rec_ready held 0 across two emits → first record held stable, second dropped, frame_err=1; MAX_RECORDS=3 with 4 changing bands → FULL after 2 records, terminator still emitted.
- Assert rst_n low while rec_valid=1 → rec_valid=0 immediately; after release, pixels ignored until first next_frame (SYNC).
